// File: rtl/prf_pkg.sv
// Shared defaults and index helpers for the multi-ported physical register file.
package prf_pkg;

   localparam int unsigned PRF_NUM_PHYS_REGS = 64;
   localparam int unsigned PRF_DATA_WIDTH    = 32;
   localparam int unsigned PRF_NUM_RD_PORTS  = 4;
   localparam int unsigned PRF_NUM_WR_PORTS  = 2;

   // Register-select width: smallest r with 2**r >= n.
   function automatic int unsigned prf_clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((r < 31) && ((32'd1 << r) < n)) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Low bit of slice idx in a flattened bus of width-bit fields.
   function automatic int unsigned prf_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

   // Select addresses an existing register.
   function automatic logic prf_in_range(input int unsigned sel, input int unsigned n);
      return sel < n;
   endfunction

   // Select addresses a register that writes and allocs may change (not reg 0).
   function automatic logic prf_writable(input int unsigned sel, input int unsigned n);
      return (sel != 0) && (sel < n);
   endfunction

endpackage

// File: rtl/prf_ready_table.sv
// Ready-bit vector: writes set, allocs clear (alloc wins), reg 0 always ready.
module prf_ready_table
   import prf_pkg::*;
#(
   parameter int unsigned NUM_PHYS_REGS = PRF_NUM_PHYS_REGS,
   parameter int unsigned NUM_WR_PORTS  = PRF_NUM_WR_PORTS,
   parameter int unsigned REGLINES      = prf_clog2(PRF_NUM_PHYS_REGS)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NUM_WR_PORTS-1:0]          wr_en_i,
   input  logic [NUM_WR_PORTS*REGLINES-1:0] wr_sel_i,
   input  logic                             alloc_en_i,
   input  logic [REGLINES-1:0]              alloc_sel_i,
   output logic [NUM_PHYS_REGS-1:0]         rdy_d_o
);

   logic [NUM_PHYS_REGS-1:0] rdy_q;
   logic [NUM_PHYS_REGS-1:0] rdy_d;
   logic [REGLINES-1:0]      sel;

   // Next ready vector; also exported so reads can bypass this edge's updates.
   always_comb begin
      rdy_d = rdy_q;
      sel   = '0;
      for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
         sel = wr_sel_i[prf_lo(w, REGLINES) +: REGLINES];
         if (wr_en_i[w] && prf_writable(32'(sel), NUM_PHYS_REGS)) begin
            rdy_d[sel] = 1'b1;
         end
      end
      if (alloc_en_i && prf_writable(32'(alloc_sel_i), NUM_PHYS_REGS)) begin
         rdy_d[alloc_sel_i] = 1'b0;
      end
      rdy_d[0] = 1'b1;
   end

   // Ready state; everything ready out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_q <= '1;
      end else begin
         rdy_q <= rdy_d;
      end
   end

   assign rdy_d_o = rdy_d;

endmodule

// File: rtl/phys_reg_file_mp.sv
// Multi-ported physical register file with write-through registered reads.
module phys_reg_file_mp
   import prf_pkg::*;
#(
   parameter  int unsigned NUM_PHYS_REGS = PRF_NUM_PHYS_REGS,
   parameter  int unsigned DATA_WIDTH    = PRF_DATA_WIDTH,
   parameter  int unsigned NUM_RD_PORTS  = PRF_NUM_RD_PORTS,
   parameter  int unsigned NUM_WR_PORTS  = PRF_NUM_WR_PORTS,
   localparam int unsigned REGLINES      = prf_clog2(NUM_PHYS_REGS)
) (
   input  logic                               CLK,
   input  logic                               RESET,
   input  logic [NUM_RD_PORTS*REGLINES-1:0]   RdSel_IN,
   output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] RdData_OUT,
   output logic [NUM_RD_PORTS-1:0]            RdReady_OUT,
   input  logic [NUM_WR_PORTS-1:0]            WrEn_IN,
   input  logic [NUM_WR_PORTS*REGLINES-1:0]   WrSel_IN,
   input  logic [NUM_WR_PORTS*DATA_WIDTH-1:0] WrData_IN,
   input  logic                               AllocEn_IN,
   input  logic [REGLINES-1:0]                AllocSel_IN,
   output logic                               WrConflict_OUT
);

   logic [DATA_WIDTH-1:0]              mem_q [NUM_PHYS_REGS];
   logic [DATA_WIDTH-1:0]              mem_d [NUM_PHYS_REGS];
   logic [NUM_PHYS_REGS-1:0]           rdy_d;
   logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [NUM_RD_PORTS-1:0]            rd_rdy_q, rd_rdy_d;
   logic                               conflict_q, conflict_d;
   logic [REGLINES-1:0]                wsel;
   logic [REGLINES-1:0]                wsel_i, wsel_j;
   logic [REGLINES-1:0]                rsel;

   prf_ready_table #(
      .NUM_PHYS_REGS (NUM_PHYS_REGS),
      .NUM_WR_PORTS  (NUM_WR_PORTS),
      .REGLINES      (REGLINES)
   ) u_ready (
      .clk_i       (CLK),
      .rst_ni      (RESET),
      .wr_en_i     (WrEn_IN),
      .wr_sel_i    (WrSel_IN),
      .alloc_en_i  (AllocEn_IN),
      .alloc_sel_i (AllocSel_IN),
      .rdy_d_o     (rdy_d)
   );

   // Next data array; ascending port order lets the highest port win a collision.
   always_comb begin
      mem_d = mem_q;
      wsel  = '0;
      for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
         wsel = WrSel_IN[prf_lo(w, REGLINES) +: REGLINES];
         if (WrEn_IN[w] && prf_writable(32'(wsel), NUM_PHYS_REGS)) begin
            mem_d[wsel] = WrData_IN[prf_lo(w, DATA_WIDTH) +: DATA_WIDTH];
         end
      end
      mem_d[0] = '0;
   end

   // Collision detect: any two enabled ports on the same writable register.
   always_comb begin
      conflict_d = 1'b0;
      wsel_i     = '0;
      wsel_j     = '0;
      for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
         for (int unsigned j = i + 1; j < NUM_WR_PORTS; j++) begin
            wsel_i = WrSel_IN[prf_lo(i, REGLINES) +: REGLINES];
            wsel_j = WrSel_IN[prf_lo(j, REGLINES) +: REGLINES];
            if (WrEn_IN[i] && WrEn_IN[j] && (wsel_i == wsel_j) &&
                prf_writable(32'(wsel_i), NUM_PHYS_REGS)) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   // Read muxes sample next-state values so same-edge writes/allocs are visible.
   always_comb begin
      rd_data_d = '0;
      rd_rdy_d  = '0;
      rsel      = '0;
      for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
         rsel = RdSel_IN[prf_lo(p, REGLINES) +: REGLINES];
         if (prf_in_range(32'(rsel), NUM_PHYS_REGS)) begin
            rd_data_d[prf_lo(p, DATA_WIDTH) +: DATA_WIDTH] = mem_d[rsel];
            rd_rdy_d[p] = rdy_d[rsel];
         end
      end
   end

   // Storage and registered outputs, cleared asynchronously.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned r = 0; r < NUM_PHYS_REGS; r++) begin
            mem_q[r] <= '0;
         end
         rd_data_q  <= '0;
         rd_rdy_q   <= '0;
         conflict_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         rd_data_q  <= rd_data_d;
         rd_rdy_q   <= rd_rdy_d;
         conflict_q <= conflict_d;
      end
   end

   assign RdData_OUT     = rd_data_q;
   assign RdReady_OUT    = rd_rdy_q;
   assign WrConflict_OUT = conflict_q;

endmodule

// File: tb/tb_phys_reg_file_mp.sv
// Bench: directed scenarios plus random traffic against a behavioural model.
module tb_phys_reg_file_mp;

   localparam int NA = 64;
   localparam int NB = 40;

   logic clk;
   logic rst_a, rst_b;

   // Instance A (64 regs)
   logic [3:0][5:0]  rd_sel;
   logic [3:0][31:0] rd_data;
   logic [3:0]       rd_rdy;
   logic [1:0]       wr_en;
   logic [1:0][5:0]  wr_sel;
   logic [1:0][31:0] wr_data;
   logic             alloc_en;
   logic [5:0]       alloc_sel;
   logic             conf;

   // Instance B (40 regs)
   logic [3:0][5:0]  b_rd_sel;
   logic [3:0][31:0] b_rd_data;
   logic [3:0]       b_rd_rdy;
   logic [1:0]       b_wr_en;
   logic [1:0][5:0]  b_wr_sel;
   logic [1:0][31:0] b_wr_data;
   logic             b_alloc_en;
   logic [5:0]       b_alloc_sel;
   logic             b_conf;

   int total = 0;
   int bad   = 0;

   // Reference model state for instance A
   logic [31:0] m_data [NA];
   bit          m_rdy  [NA];
   logic [31:0] exp_data [4];
   logic        exp_rdy  [4];
   logic        exp_conf;

   phys_reg_file_mp #(.NUM_PHYS_REGS(NA), .DATA_WIDTH(32), .NUM_RD_PORTS(4), .NUM_WR_PORTS(2)) u_dut_a (
      .CLK(clk), .RESET(rst_a), .RdSel_IN(rd_sel), .RdData_OUT(rd_data), .RdReady_OUT(rd_rdy),
      .WrEn_IN(wr_en), .WrSel_IN(wr_sel), .WrData_IN(wr_data),
      .AllocEn_IN(alloc_en), .AllocSel_IN(alloc_sel), .WrConflict_OUT(conf)
   );

   phys_reg_file_mp #(.NUM_PHYS_REGS(NB), .DATA_WIDTH(32), .NUM_RD_PORTS(4), .NUM_WR_PORTS(2)) u_dut_b (
      .CLK(clk), .RESET(rst_b), .RdSel_IN(b_rd_sel), .RdData_OUT(b_rd_data), .RdReady_OUT(b_rd_rdy),
      .WrEn_IN(b_wr_en), .WrSel_IN(b_wr_sel), .WrData_IN(b_wr_data),
      .AllocEn_IN(b_alloc_en), .AllocSel_IN(b_alloc_sel), .WrConflict_OUT(b_conf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NA; r++) begin
         m_data[r] = '0;
         m_rdy[r]  = 1'b1;
      end
      for (int p = 0; p < 4; p++) begin
         exp_data[p] = '0;
         exp_rdy[p]  = 1'b0;
      end
      exp_conf = 1'b0;
   endtask

   // One clock edge of the architectural behaviour of instance A.
   task automatic model_edge();
      int s;
      exp_conf = 1'b0;
      for (int w = 0; w < 2; w++) begin
         s = int'(wr_sel[w]);
         if (wr_en[w] && s != 0 && s < NA) begin
            m_data[s] = wr_data[w];
            m_rdy[s]  = 1'b1;
         end
      end
      if (wr_en[0] && wr_en[1] && wr_sel[0] == wr_sel[1] && wr_sel[0] != 0) exp_conf = 1'b1;
      s = int'(alloc_sel);
      if (alloc_en && s != 0 && s < NA) m_rdy[s] = 1'b0;
      for (int p = 0; p < 4; p++) begin
         s = int'(rd_sel[p]);
         exp_data[p] = (s < NA) ? m_data[s] : 32'h0;
         exp_rdy[p]  = (s < NA) ? m_rdy[s]  : 1'b0;
      end
   endtask

   task automatic check_a();
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("a_rd%0d_data", p), rd_data[p], exp_data[p]);
         chk($sformatf("a_rd%0d_rdy", p), {31'b0, rd_rdy[p]}, {31'b0, exp_rdy[p]});
      end
      chk("a_conflict", {31'b0, conf}, {31'b0, exp_conf});
   endtask

   task automatic check_b_zero(input string tag);
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("%s_b_rd%0d_data", tag, p), b_rd_data[p], 32'h0);
         chk($sformatf("%s_b_rd%0d_rdy", tag, p), {31'b0, b_rd_rdy[p]}, 32'h0);
      end
      chk($sformatf("%s_b_conflict", tag), {31'b0, b_conf}, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_a) model_edge();
      #1;
      check_a();
   endtask

   task automatic idle_a();
      wr_en = '0; wr_sel = '0; wr_data = '0; alloc_en = 1'b0; alloc_sel = '0;
   endtask

   task automatic rand_a();
      for (int w = 0; w < 2; w++) begin
         wr_en[w]   = 1'($urandom_range(0, 1));
         wr_sel[w]  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
         wr_data[w] = $urandom;
      end
      alloc_en  = ($urandom_range(0, 3) == 0);
      alloc_sel = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      for (int p = 0; p < 4; p++)
         rd_sel[p] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom);
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      idle_a(); rd_sel = '0;
      b_wr_en = '0; b_wr_sel = '0; b_wr_data = '0; b_alloc_en = 1'b0; b_alloc_sel = '0; b_rd_sel = '0;
      model_reset();
      #12;
      check_a();
      check_b_zero("reset");

      // Reset values through first reads
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;
      rd_sel[0] = 6'd5; rd_sel[1] = 6'd0; rd_sel[2] = 6'd63; rd_sel[3] = 6'd5;
      tick();
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("post_reset_rd%0d", p), rd_data[p], 32'h0);
         chk($sformatf("post_reset_rdy%0d", p), {31'b0, rd_rdy[p]}, 32'h1);
      end

      // Alloc then write-through read
      alloc_en = 1'b1; alloc_sel = 6'd7; rd_sel[1] = 6'd7;
      tick();
      chk("alloc7_rdy", {31'b0, rd_rdy[1]}, 32'h0);
      idle_a(); wr_en[0] = 1'b1; wr_sel[0] = 6'd7; wr_data[0] = 32'hDEADBEEF;
      tick();
      chk("wr7_data", rd_data[1], 32'hDEADBEEF);
      chk("wr7_rdy", {31'b0, rd_rdy[1]}, 32'h1);

      // Same-register collision
      idle_a(); wr_en = 2'b11; wr_sel[0] = 6'd9; wr_sel[1] = 6'd9;
      wr_data[0] = 32'h11; wr_data[1] = 32'h22; rd_sel[0] = 6'd9;
      tick();
      chk("coll_data", rd_data[0], 32'h22);
      chk("coll_flag", {31'b0, conf}, 32'h1);
      idle_a();
      tick();
      chk("coll_flag_drop", {31'b0, conf}, 32'h0);

      // Alloc and write on the same edge
      wr_en[0] = 1'b1; wr_sel[0] = 6'd12; wr_data[0] = 32'h5A;
      alloc_en = 1'b1; alloc_sel = 6'd12; rd_sel[2] = 6'd12;
      tick();
      chk("allocwr_data", rd_data[2], 32'h5A);
      chk("allocwr_rdy", {31'b0, rd_rdy[2]}, 32'h0);

      // Register 0 is immutable and never flags a conflict
      idle_a(); wr_en = 2'b11; wr_sel = '0; wr_data[0] = 32'hFFFF_FFFF; wr_data[1] = 32'h1234;
      alloc_en = 1'b1; alloc_sel = 6'd0; rd_sel[3] = 6'd0;
      tick();
      chk("r0_data", rd_data[3], 32'h0);
      chk("r0_rdy", {31'b0, rd_rdy[3]}, 32'h1);
      chk("r0_noconf", {31'b0, conf}, 32'h0);
      idle_a();

      // Non-power-of-two instance: mid-cycle reset drops pending write
      b_wr_en = 2'b01; b_wr_sel[0] = 6'd3; b_wr_data[0] = 32'h1; b_rd_sel[0] = 6'd3;
      tick();
      chk("b_wr3_data", b_rd_data[0], 32'h1);
      chk("b_wr3_rdy", {31'b0, b_rd_rdy[0]}, 32'h1);
      b_wr_sel[0] = 6'd4; b_wr_data[0] = 32'h77;
      b_rd_sel[0] = 6'd4; b_rd_sel[1] = 6'd3; b_rd_sel[2] = 6'd45; b_rd_sel[3] = 6'd0;
      #3; rst_b = 1'b0; #1;
      check_b_zero("async");
      tick();
      check_b_zero("held");
      b_wr_en = '0;
      @(negedge clk); rst_b = 1'b1;
      tick();
      chk("b_r4_data", b_rd_data[0], 32'h0);
      chk("b_r4_rdy", {31'b0, b_rd_rdy[0]}, 32'h1);
      chk("b_r3_data", b_rd_data[1], 32'h0);
      chk("b_r3_rdy", {31'b0, b_rd_rdy[1]}, 32'h1);
      chk("b_r45_data", b_rd_data[2], 32'h0);
      chk("b_r45_rdy", {31'b0, b_rd_rdy[2]}, 32'h0);
      chk("b_r0_data", b_rd_data[3], 32'h0);
      chk("b_r0_rdy", {31'b0, b_rd_rdy[3]}, 32'h1);

      // Random traffic on instance A
      for (int k = 0; k < 400; k++) begin
         rand_a();
         tick();
      end

      // Mid-run reset of A with random traffic pending
      rand_a();
      #2; rst_a = 1'b0; model_reset(); #1;
      check_a();
      tick();
      rst_a = 1'b1;
      for (int k = 0; k < 200; k++) begin
         rand_a();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
